// File: rtl/ram128_arb_pkg.sv
// Shared constants and FSM encoding for the two-port arbiter around a 128x1 RAM.
package ram128_arb_pkg;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/RAM128X1S.sv
// 128x1 distributed RAM: asynchronous read, synchronous write on WCLK.
module RAM128X1S #(
    parameter logic IS_WCLK_INVERTED = 1'b0
) (
    output logic O,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    input  logic D,
    input  logic WCLK,
    input  logic WE
);

    logic [127:0] mem;
    logic [6:0]   addr;
    logic         wclk_int;

    assign addr     = {A6, A5, A4, A3, A2, A1, A0};
    assign wclk_int = WCLK ^ IS_WCLK_INVERTED;
    assign O        = mem[addr];

    always_ff @(posedge wclk_int) begin
        if (WE) begin
            mem[addr] <= D;
        end
    end

endmodule

// File: rtl/ram128_arbiter.sv
// Round-robin arbiter sharing one 128x1 RAM between two requesters, with a
// full clear sweep after reset and on a CLR pulse.
module ram128_arbiter
    import ram128_arb_pkg::*;
#(
    parameter logic CLR_VAL         = 1'b0,
    parameter logic IS_CLK_INVERTED = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLR,
    output logic       BUSY,
    input  logic       REQ0_VALID,
    input  logic       REQ1_VALID,
    input  logic       REQ0_WE,
    input  logic       REQ1_WE,
    input  logic [6:0] REQ0_ADDR,
    input  logic [6:0] REQ1_ADDR,
    input  logic       REQ0_WDATA,
    input  logic       REQ1_WDATA,
    output logic       REQ0_READY,
    output logic       REQ1_READY,
    output logic       RSP0_VALID,
    output logic       RSP1_VALID,
    output logic       RSP0_RDATA,
    output logic       RSP1_RDATA
);

    logic              clk_int;
    arb_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              ptr, ptr_nxt;
    logic              gnt0, gnt1;
    logic              ram_we, ram_d, ram_o;
    logic [ADDR_W-1:0] ram_a;
    logic              rsp0_vld_p1, rsp1_vld_p1;
    logic              rsp0_rdata_p1, rsp1_rdata_p1;

    assign clk_int = CLK ^ IS_CLK_INVERTED;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ram_we    = 1'b0;
        ram_a     = cnt;
        ram_d     = CLR_VAL;
        case (state)
            CLEAR: begin
                ram_we  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                // CLR wins over any request presented in the same cycle
                if (CLR) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    gnt0 = REQ0_VALID && (!REQ1_VALID || !ptr);
                    gnt1 = REQ1_VALID && (!REQ0_VALID || ptr);
                    if (gnt0) begin
                        ram_we  = REQ0_WE;
                        ram_a   = REQ0_ADDR;
                        ram_d   = REQ0_WDATA;
                        ptr_nxt = 1'b1;
                    end else if (gnt1) begin
                        ram_we  = REQ1_WE;
                        ram_a   = REQ1_ADDR;
                        ram_d   = REQ1_WDATA;
                        ptr_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Stage p1: state update and registered read responses
    always_ff @(posedge clk_int) begin
        if (RST) begin
            state         <= CLEAR;
            cnt           <= '0;
            ptr           <= 1'b0;
            rsp0_vld_p1   <= 1'b0;
            rsp1_vld_p1   <= 1'b0;
            rsp0_rdata_p1 <= 1'b0;
            rsp1_rdata_p1 <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ptr         <= ptr_nxt;
            rsp0_vld_p1 <= gnt0 && !REQ0_WE;
            rsp1_vld_p1 <= gnt1 && !REQ1_WE;
            if (gnt0 && !REQ0_WE) begin
                rsp0_rdata_p1 <= ram_o;
            end
            if (gnt1 && !REQ1_WE) begin
                rsp1_rdata_p1 <= ram_o;
            end
        end
    end

    assign BUSY       = (state == CLEAR);
    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;
    assign RSP0_VALID = rsp0_vld_p1;
    assign RSP1_VALID = rsp1_vld_p1;
    assign RSP0_RDATA = rsp0_rdata_p1;
    assign RSP1_RDATA = rsp1_rdata_p1;

    RAM128X1S #(
        .IS_WCLK_INVERTED(IS_CLK_INVERTED)
    ) u_ram (
        .O   (ram_o),
        .A0  (ram_a[0]),
        .A1  (ram_a[1]),
        .A2  (ram_a[2]),
        .A3  (ram_a[3]),
        .A4  (ram_a[4]),
        .A5  (ram_a[5]),
        .A6  (ram_a[6]),
        .D   (ram_d),
        .WCLK(CLK),
        .WE  (ram_we)
    );

    // A pending command must stay valid and unchanged until it is accepted
    a_req0_hold: assert property (@(posedge clk_int) disable iff (RST)
        (REQ0_VALID && !REQ0_READY) |=> (REQ0_VALID && $stable(REQ0_WE) &&
                                         $stable(REQ0_ADDR) && $stable(REQ0_WDATA)));
    a_req1_hold: assert property (@(posedge clk_int) disable iff (RST)
        (REQ1_VALID && !REQ1_READY) |=> (REQ1_VALID && $stable(REQ1_WE) &&
                                         $stable(REQ1_ADDR) && $stable(REQ1_WDATA)));

endmodule

// File: tb/tb_ram128_arbiter.sv
// Bench for ram128_arbiter: directed sequences, a vector table, and random
// traffic checked against a behavioural memory/arbitration model.
module tb_ram128_arbiter;

    localparam logic CLR_V = 1'b0;

    logic       CLK = 1'b0;
    logic       RST, CLR;
    logic       v0, we0, d0, v1, we1, d1;
    logic [6:0] a0, a1;
    logic       BUSY, REQ0_READY, REQ1_READY;
    logic       RSP0_VALID, RSP1_VALID, RSP0_RDATA, RSP1_RDATA;

    ram128_arbiter #(.CLR_VAL(CLR_V), .IS_CLK_INVERTED(1'b0)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY),
        .REQ0_VALID(v0), .REQ1_VALID(v1), .REQ0_WE(we0), .REQ1_WE(we1),
        .REQ0_ADDR(a0), .REQ1_ADDR(a1), .REQ0_WDATA(d0), .REQ1_WDATA(d1),
        .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
        .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
        .RSP0_RDATA(RSP0_RDATA), .RSP1_RDATA(RSP1_RDATA)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining sweep cycles, whole-memory image, pointer.
    int   clear_left = 0;
    bit   m_ptr;
    bit   mem [128];
    bit   e_rv0, e_rv1, e_rd0, e_rd1;
    bit   known = 1'b0;
    bit   mg0, mg1;
    logic last_busy, last_rdy0, last_rdy1;
    int   cyc, first_rdy0;

    typedef struct {
        logic v0, we0; logic [6:0] a0; logic d0;
        logic v1, we1; logic [6:0] a1; logic d1;
        logic r0, r1, rv0, rv1, rd0, rd1;
    } vec_t;
    vec_t tbl [6];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic mem_fill();
        for (int i = 0; i < 128; i++) mem[i] = CLR_V;
    endtask

    task automatic step();
        @(negedge CLK);
        last_busy = BUSY;
        last_rdy0 = REQ0_READY;
        last_rdy1 = REQ1_READY;
        mg0 = 1'b0;
        mg1 = 1'b0;
        if (known) begin
            cyc++;
            if (last_rdy0 && first_rdy0 == 0) first_rdy0 = cyc;
            if (clear_left == 0 && !CLR) begin
                if (v0 && v1) begin
                    mg0 = !m_ptr;
                    mg1 = m_ptr;
                end else begin
                    mg0 = v0;
                    mg1 = v1;
                end
            end
            check1("busy", BUSY, clear_left > 0);
            check1("ready0", REQ0_READY, mg0);
            check1("ready1", REQ1_READY, mg1);
        end
        @(posedge CLK);
        if (RST) begin
            clear_left = 128;
            m_ptr = 1'b0;
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 1'b0; e_rd1 = 1'b0;
            mem_fill();
            known = 1'b1;
            cyc = 0;
            first_rdy0 = 0;
        end else if (known) begin
            e_rv0 = 1'b0;
            e_rv1 = 1'b0;
            if (clear_left > 0) begin
                clear_left--;
            end else if (CLR) begin
                clear_left = 128;
                mem_fill();
            end else if (mg0) begin
                m_ptr = 1'b1;
                if (we0) mem[a0] = d0;
                else begin e_rv0 = 1'b1; e_rd0 = mem[a0]; end
            end else if (mg1) begin
                m_ptr = 1'b0;
                if (we1) mem[a1] = d1;
                else begin e_rv1 = 1'b1; e_rd1 = mem[a1]; end
            end
        end
        #1;
        if (known) begin
            check1("rsp0_valid", RSP0_VALID, e_rv0);
            check1("rsp1_valid", RSP1_VALID, e_rv1);
            check1("rsp0_rdata", RSP0_RDATA, e_rd0);
            check1("rsp1_rdata", RSP1_RDATA, e_rd1);
        end
    endtask

    task automatic count_busy(input int clr_at, output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            CLR = (i == clr_at);
            step();
            if (last_busy) n++;
            else break;
        end
        CLR = 1'b0;
    endtask

    task automatic idle();
        v0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = 1'b0;
        v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = 1'b0;
    endtask

    initial begin
        int n;
        int t;
        tbl[0] = '{1'b1, 1'b1, 7'd3, 1'b1, 1'b1, 1'b1, 7'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 7'd3, 1'b0, 1'b1, 1'b1, 7'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 7'd3, 1'b0, 1'b1, 1'b0, 7'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 7'd5, 1'b0, 1'b1, 1'b0, 7'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        idle();
        RST = 1'b1;
        CLR = 1'b0;
        step();
        step();
        check1("rst_busy", BUSY, 1'b1);
        check1("rst_ready0", REQ0_READY, 1'b0);
        check1("rst_ready1", REQ1_READY, 1'b0);
        check1("rst_rsp0_valid", RSP0_VALID, 1'b0);
        check1("rst_rsp1_rdata", RSP1_RDATA, 1'b0);

        // Held read through the post-reset sweep, then read back every address
        RST = 1'b0;
        v0 = 1'b1; we0 = 1'b0;
        for (int k = 0; k < 128; k++) begin
            a0 = 7'(k);
            t = 0;
            do begin
                step();
                t++;
            end while (!mg0 && t < 200);
            check1("read_grant", last_rdy0, 1'b1);
            check1("read_clr_val", RSP0_RDATA, CLR_V);
            if (k == 0) checkn("first_ready_cycle", first_rdy0, 129);
        end
        v0 = 1'b0;

        // Write then read-after-write from the other port
        v0 = 1'b1; we0 = 1'b1; a0 = 7'd5; d0 = 1'b1;
        step();
        check1("raw_wr_ready", last_rdy0, 1'b1);
        idle();
        v1 = 1'b1; we1 = 1'b0; a1 = 7'd5;
        step();
        check1("raw_rd_ready", last_rdy1, 1'b1);
        check1("raw_rsp1_valid", RSP1_VALID, 1'b1);
        check1("raw_rsp1_rdata", RSP1_RDATA, 1'b1);
        check1("raw_rsp0_quiet", RSP0_VALID, 1'b0);
        idle();
        step();
        check1("raw_rsp1_one_cycle", RSP1_VALID, 1'b0);
        check1("raw_rsp1_hold", RSP1_RDATA, 1'b1);

        // Fresh reset, then the round-robin vector table
        RST = 1'b1;
        step();
        RST = 1'b0;
        count_busy(-1, n);
        checkn("sweep_len_reset", n, 128);
        for (int i = 0; i < 6; i++) begin
            v0 = tbl[i].v0; we0 = tbl[i].we0; a0 = tbl[i].a0; d0 = tbl[i].d0;
            v1 = tbl[i].v1; we1 = tbl[i].we1; a1 = tbl[i].a1; d1 = tbl[i].d1;
            step();
            check1("tbl_ready0", last_rdy0, tbl[i].r0);
            check1("tbl_ready1", last_rdy1, tbl[i].r1);
            check1("tbl_rsp0_valid", RSP0_VALID, tbl[i].rv0);
            check1("tbl_rsp1_valid", RSP1_VALID, tbl[i].rv1);
            check1("tbl_rsp0_rdata", RSP0_RDATA, tbl[i].rd0);
            check1("tbl_rsp1_rdata", RSP1_RDATA, tbl[i].rd1);
        end

        // CLR beats a simultaneous request; address 5 reads CLR_VAL afterwards
        idle();
        v0 = 1'b1; we0 = 1'b1; a0 = 7'd5; d0 = 1'b1;
        step();
        idle();
        CLR = 1'b1;
        v1 = 1'b1; we1 = 1'b0; a1 = 7'd5;
        step();
        check1("clr_no_ready0", last_rdy0, 1'b0);
        check1("clr_no_ready1", last_rdy1, 1'b0);
        CLR = 1'b0;
        count_busy(-1, n);
        checkn("sweep_len_clr", n, 128);
        check1("clr_held_grant", last_rdy1, 1'b1);
        check1("clr_rsp1_valid", RSP1_VALID, 1'b1);
        check1("clr_rsp1_rdata", RSP1_RDATA, CLR_V);
        idle();

        // RST at sweep address 60 restarts the sweep
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        for (int i = 0; i < 60; i++) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        count_busy(-1, n);
        checkn("sweep_len_rst_mid", n, 128);

        // Read of 127 just before CLR still responds; CLR during sweep is ignored
        v0 = 1'b1; we0 = 1'b1; a0 = 7'd127; d0 = 1'b1;
        step();
        we0 = 1'b0;
        step();
        check1("preclr_rsp0_valid", RSP0_VALID, 1'b1);
        check1("preclr_rsp0_rdata", RSP0_RDATA, 1'b1);
        idle();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        count_busy(10, n);
        checkn("sweep_len_clr_ignored", n, 128);
        v0 = 1'b1; we0 = 1'b0; a0 = 7'd127;
        step();
        check1("postclr_rdata", RSP0_RDATA, CLR_V);
        idle();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (!v0 || mg0) begin
                v0  = ($urandom_range(3) != 0);
                we0 = 1'($urandom_range(1));
                a0  = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(7));
                d0  = 1'($urandom_range(1));
            end
            if (!v1 || mg1) begin
                v1  = ($urandom_range(3) != 0);
                we1 = 1'($urandom_range(1));
                a1  = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(7));
                d1  = 1'($urandom_range(1));
            end
            CLR = ($urandom_range(149) == 0);
            RST = ($urandom_range(699) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram128_arbiter.md
RAM128_ARBITER -- requirements
Module: ram128_arbiter

Interface
REQ-001 SHALL have parameter CLR_VAL, default 1'b0: bit value written to every location during a clear sweep.
REQ-002 SHALL have parameter IS_CLK_INVERTED, default 1'b0: when 1, all sequential logic and the RAM write use the falling edge of CLK.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state and RAM writes are on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port CLR, input, 1: a one-cycle pulse that requests a full clear sweep.
REQ-006 SHALL have port BUSY, output, 1: high while a clear sweep is in progress.
REQ-007 SHALL have ports REQ0_VALID, input, 1 and REQ1_VALID, input, 1: requester command valid.
REQ-008 SHALL have ports REQ0_WE, input, 1 and REQ1_WE, input, 1: 1 means write, 0 means read.
REQ-009 SHALL have ports REQ0_ADDR, input, 7 and REQ1_ADDR, input, 7: RAM address.
REQ-010 SHALL have ports REQ0_WDATA, input, 1 and REQ1_WDATA, input, 1: write data.
REQ-011 SHALL have ports REQ0_READY, output, 1 and REQ1_READY, output, 1: command accepted this cycle.
REQ-012 SHALL have ports RSP0_VALID, output, 1 and RSP1_VALID, output, 1: read response valid.
REQ-013 SHALL have ports RSP0_RDATA, output, 1 and RSP1_RDATA, output, 1: read data.

Function
REQ-014 SHALL share one 128x1 distributed RAM with asynchronous read and synchronous write between two requesters.
REQ-015 SHALL implement an FSM with exactly two states, CLEAR and SERVE.
REQ-016 In CLEAR, SHALL write CLR_VAL to address = sweep counter every cycle, counting 0..127, with BUSY=1 and both READY=0.
REQ-017 SHALL transition from CLEAR to SERVE in the cycle after the write to address 127, so a sweep lasts exactly 128 cycles.
REQ-018 In SERVE, SHALL accept at most one command per cycle; REQn_READY=1 only in the cycle its command is accepted.
REQ-019 SHALL drive REQn_READY combinationally from state, VALIDs and the priority pointer, never from READY feedback.
REQ-020 Arbitration: a sole valid requester SHALL win; when both are valid, the requester named by the priority pointer SHALL win.
REQ-021 The priority pointer SHALL reset to requester 0 and SHALL move to the other requester after every grant (round-robin).
REQ-022 An accepted write SHALL update the RAM at that clock edge and SHALL produce no response.
REQ-023 An accepted read SHALL register the asynchronous RAM output, giving RSPn_VALID=1 and RSPn_RDATA valid exactly 1 cycle after acceptance, held for one cycle.
REQ-024 RSPn_RDATA SHALL hold its last value when RSPn_VALID=0.
REQ-025 A read issued in the cycle after a write to the same address SHALL return the newly written value.
REQ-026 When CLR=1 in SERVE, the block SHALL grant nothing that cycle and SHALL enter CLEAR with the counter at 0 (CLR beats a simultaneous request).
REQ-027 CLR=1 while in CLEAR SHALL be ignored; the sweep is not restarted.
REQ-028 A read accepted in the cycle before CLR is asserted SHALL still deliver its response in the next cycle.
REQ-029 A requester SHALL hold VALID and its command stable until READY; this is a requester obligation, checked by assertion.

Reset
REQ-030 While RST=1 at a clock edge: state SHALL become CLEAR, counter 0, pointer 0, RSP0/1_VALID 0, RSP0/1_RDATA 0.
REQ-031 In the cycles after RST is released, BUSY SHALL be 1 and both READY 0; a full 128-cycle sweep SHALL run before the first grant.
REQ-032 RST asserted mid-sweep or mid-transaction SHALL abort it, drop any pending response, and restart the sweep at address 0.

Structure
REQ-033 Shared package ram128_arb_pkg SHALL hold DEPTH=128, ADDR_W=7 and the FSM state enumeration {CLEAR, SERVE}.
REQ-034 SHALL contain exactly one sub-module, an instance of the existing RAM128X1S primitive, with WE, D and address A6..A0 muxed between the sweep counter and the granted requester.
REQ-035 SHALL pass IS_CLK_INVERTED through to the IS_WCLK_INVERTED parameter of the RAM128X1S instance.

Verification
REQ-036 Release RST and hold REQ0_VALID=1 -> BUSY=1 for 128 cycles, REQ0_READY first high in cycle 129; reads of addresses 0..127 return CLR_VAL.
REQ-037 REQ0 writes 1 to address 5, next cycle REQ1 reads address 5 -> RSP1_VALID=1 with RSP1_RDATA=1 one cycle after acceptance.
REQ-038 Both VALID held high for 4 cycles after reset -> grant order 0,1,0,1; each response appears only on its own port.
REQ-039 CLR pulsed in the same cycle as REQ1_VALID=1 -> no READY that cycle, BUSY=1 for 128 cycles; address 5 then reads CLR_VAL.
REQ-040 RST pulsed at sweep address 60 -> sweep restarts at 0; BUSY stays high for 128 further cycles; no stray RSP_VALID.
REQ-041 Read of address 127 accepted, then CLR the next cycle -> RSP_VALID delivered with pre-clear data; CLR during the sweep does not extend BUSY.
